// File: rtl/fejkon_led_pkg.sv
// Shared types for the LED conditioning stage: activity states, ms-counter width, fast-sim tick divisor.
package fejkon_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } act_state_t;

  localparam int FASTSIM_DIV = 16;

  typedef logic [7:0] ms_cnt_t;

endpackage

// File: rtl/fejkon_led_activity_if.sv
// Per-port LED signal bundle between the FC port logic and fejkon_led; no flow control, every signal is level/strobe.
interface fejkon_led_activity_if #(
  parameter int Ports = 4
);

  logic [Ports-1:0] fcport_frame;
  logic [Ports-1:0] fcport_aligned_raw;
  logic [Ports-1:0] fcport_active;
  logic [Ports-1:0] fcport_aligned;
  logic             ms_tick;

  modport master (
    output fcport_frame,
    output fcport_aligned_raw,
    input  fcport_active,
    input  fcport_aligned,
    input  ms_tick
  );

  modport slave (
    input  fcport_frame,
    input  fcport_aligned_raw,
    output fcport_active,
    output fcport_aligned,
    output ms_tick
  );

endinterface

// File: rtl/fejkon_led_port.sv
// One port: frame pulses -> rate-limited blink (active next cycle after a pulse from IDLE), raw alignment -> 2-FF sync + ms debounce.
// No backpressure; frames arriving during a blink are folded into a single pending flag.
module fejkon_led_port
  import fejkon_led_pkg::*;
#(
  parameter int StretchMs  = 50,
  parameter int DebounceMs = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ms_tick,
  input  logic frame,
  input  logic aligned_raw,
  output logic active,
  output logic aligned
);

  localparam ms_cnt_t StretchLast  = ms_cnt_t'(StretchMs - 1);
  localparam ms_cnt_t DebounceLast = ms_cnt_t'(DebounceMs - 1);

  act_state_t state, state_nxt;
  ms_cnt_t    cnt, cnt_nxt;
  logic       pending, pending_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  // ON and OFF share the tick counting; only the exit decision differs.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    active      = (state == ON);
    case (state)
      IDLE: begin
        if (frame) begin
          state_nxt   = ON;
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
        end
      end
      ON: begin
        pending_nxt = pending | frame;
        if (ms_tick) begin
          if (cnt == StretchLast) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      OFF: begin
        pending_nxt = pending | frame;
        if (ms_tick) begin
          if (cnt == StretchLast) begin
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
            state_nxt   = (pending || frame) ? ON : IDLE;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  logic [1:0] sync_q;
  ms_cnt_t    deb_cnt;

  // Any cycle where the synchronised level agrees with the output restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      deb_cnt <= '0;
      aligned <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], aligned_raw};
      if (sync_q[1] != aligned) begin
        if (ms_tick) begin
          if (deb_cnt == DebounceLast) begin
            aligned <= sync_q[1];
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 8'd1;
          end
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fejkon_led_activity.sv
// LED conditioning for all FC ports: free-running ms tick plus one fejkon_led_port per port.
// FEJKON_LED_FASTSIM_EN shrinks the tick divisor to FASTSIM_DIV for simulation; no backpressure anywhere.
module fejkon_led_activity
  import fejkon_led_pkg::*;
#(
  parameter int ReferenceClock = 50000000,
  parameter int Ports          = 4,
  parameter int StretchMs      = 50,
  parameter int DebounceMs     = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fejkon_led_activity_if.slave  led
);

`ifdef FEJKON_LED_FASTSIM_EN
  localparam int TickDiv = FASTSIM_DIV;
`else
  localparam int TickDiv = ReferenceClock / 1000;
`endif
  localparam int TickW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);

  logic [TickW-1:0] tick_cnt;
  logic             ms_tick;
  logic [Ports-1:0] active_v;
  logic [Ports-1:0] aligned_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TickLast) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign ms_tick = (tick_cnt == TickLast);

  for (genvar g = 0; g < Ports; g++) begin : g_port
    fejkon_led_port #(
      .StretchMs  (StretchMs),
      .DebounceMs (DebounceMs)
    ) u_port (
      .clk         (clk),
      .reset_n     (reset_n),
      .ms_tick     (ms_tick),
      .frame       (led.fcport_frame[g]),
      .aligned_raw (led.fcport_aligned_raw[g]),
      .active      (active_v[g]),
      .aligned     (aligned_v[g])
    );
  end

  assign led.ms_tick        = ms_tick;
  assign led.fcport_active  = active_v;
  assign led.fcport_aligned = aligned_v;

endmodule

// File: tb/tb_fejkon_led_activity.sv
// Bench for fejkon_led_activity: tick-ordinal reference model feeds an expectation queue, a monitor compares every cycle.
module tb_fejkon_led_activity;

  localparam int P   = 4;
  localparam int S   = 2;
  localparam int D   = 3;
  localparam int DIV = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  fejkon_led_activity_if #(.Ports(P)) led ();

  fejkon_led_activity #(
    .ReferenceClock (16000),
    .Ports          (P),
    .StretchMs      (S),
    .DebounceMs     (D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led     (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         tick;
    logic [P-1:0] act;
    logic [P-1:0] aln;
    logic [31:0]  cyc;
  } exp_t;

  exp_t expq[$];
  int errors = 0;
  int checks = 0;

  // Reference model: time measured as tick ordinals; a blink that starts with b ticks
  // already elapsed is ON until tick b+S and OFF until tick b+2S.
  int           cyc;
  bit           busy [P];
  int           bstart [P];
  bit           pend [P];
  logic [P-1:0] m_aln;
  bit           dis [P];
  int           dstart [P];
  logic [P-1:0] rawq[$];

  always @(negedge clk) begin
    int           g;
    bit           tk;
    bit           f;
    logic [P-1:0] s;
    exp_t         e;
    if (!reset_n) begin
      cyc = 0;
      m_aln = '0;
      rawq.delete();
      for (int p = 0; p < P; p++) begin
        busy[p] = 0; bstart[p] = 0; pend[p] = 0; dis[p] = 0; dstart[p] = 0;
      end
      e = '0;
      e.cyc = 32'hffff_ffff;
      expq.push_back(e);
    end else begin
      g  = cyc / DIV;
      tk = (cyc % DIV) == DIV - 1;
      s  = (cyc >= 2) ? rawq[cyc-2] : '0;
      e.tick = tk;
      e.aln  = m_aln;
      e.cyc  = cyc;
      for (int p = 0; p < P; p++) e.act[p] = busy[p] && (g < bstart[p] + S);
      expq.push_back(e);
      rawq.push_back(led.fcport_aligned_raw);
      for (int p = 0; p < P; p++) begin
        f = led.fcport_frame[p];
        if (busy[p]) begin
          if (tk && (g + 1 == bstart[p] + 2*S)) begin
            if (pend[p] || f) begin
              bstart[p] = bstart[p] + 2*S;
              pend[p] = 0;
            end else begin
              busy[p] = 0;
            end
          end else if (f) begin
            pend[p] = 1;
          end
        end else if (f) begin
          busy[p] = 1;
          bstart[p] = g + int'(tk);
          pend[p] = 0;
        end
        if (s[p] != m_aln[p]) begin
          if (!dis[p]) begin
            dis[p] = 1;
            dstart[p] = g;
          end
          if (tk && (g + 1 - dstart[p] == D)) begin
            m_aln[p] = s[p];
            dis[p] = 0;
          end
        end else begin
          dis[p] = 0;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      checks++;
      if (led.ms_tick !== e.tick) begin
        errors++;
        $display("FAIL ms_tick cyc=%0d got=%b expected=%b", e.cyc, led.ms_tick, e.tick);
      end
      checks++;
      if (led.fcport_active !== e.act) begin
        errors++;
        $display("FAIL fcport_active cyc=%0d got=%b expected=%b", e.cyc, led.fcport_active, e.act);
      end
      checks++;
      if (led.fcport_aligned !== e.aln) begin
        errors++;
        $display("FAIL fcport_aligned cyc=%0d got=%b expected=%b", e.cyc, led.fcport_aligned, e.aln);
      end
    end
  end

  logic [P-1:0] raw_v = '0;

  task automatic step(input logic [P-1:0] fr);
    @(posedge clk);
    #1;
    led.fcport_frame       = fr;
    led.fcport_aligned_raw = raw_v;
  endtask

  initial begin
    led.fcport_frame       = '0;
    led.fcport_aligned_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Quiet run: tick cadence and all-zero outputs.
    repeat (200) step('0);

    // Single pulse on port 0.
    step(4'b0001);
    repeat (99) step('0);

    // Dense traffic on port 2.
    for (int i = 0; i < 500; i++) step((i % 5 == 0) ? 4'b0100 : 4'b0000);
    repeat (100) step('0);

    // Stable rising alignment on port 1.
    raw_v[1] = 1'b1;
    repeat (100) step('0);

    // Port 0 alignment with a 5-cycle dropout every 40 cycles.
    for (int i = 0; i < 400; i++) begin
      raw_v[0] = !((i % 40) < 5);
      step('0);
    end
    raw_v[0] = 1'b0;
    repeat (80) step('0);

    // Random traffic and slow alignment chatter on all ports.
    for (int i = 0; i < 2000; i++) begin
      logic [P-1:0] fr;
      for (int p = 0; p < P; p++) begin
        fr[p] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 59) == 0) raw_v[p] = ~raw_v[p];
      end
      step(fr);
    end
    repeat (100) step('0);

    // Reset while port 3 is ON with a pending frame.
    step(4'b1000);
    repeat (3) step('0);
    step(4'b1000);
    step('0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (led.fcport_active !== '0) begin
      errors++;
      $display("FAIL async_reset_active got=%b expected=%b", led.fcport_active, {P{1'b0}});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (200) step('0);

    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
